lc3_psr_cc: RTL and testbench

//  Parametrised condition-code / processor-status unit for the LC-3 datapath.

---
 rtl/lc3_psr_cc.sv | 177 +++++++++++++++++
 tb/tb_lc3_psr_cc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_psr_cc.sv
// LC-3 condition-code / processor-status unit.
// - Derives N/Z/P from the data bus and registers the BR branch enable.
// - Holds the PSR privilege and priority fields.
// - Keeps a small hardware shadow stack of PSR images. Interrupt entry pushes
//   onto it and RTI pops from it. Sticky flags record overflow and underflow.
module lc3_psr_cc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_bus,
    input  logic [15:0]      ir,
    input  logic             ld_cc,
    input  logic             ld_ben,
    input  logic             ld_psr,
    input  logic             int_push,
    input  logic [2:0]       int_pri,
    input  logic             rti_pop,
    input  logic             err_clr,
    output logic             ben,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             priv,
    output logic [2:0]       pri,
    output logic [15:0]      psr,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_ovf,
    output logic             stk_unf
);

    // Occupancy counts 0..DEPTH, so it needs one more code than an index.
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << IW;
    localparam logic [PW-1:0] OCC_MAX = PW'(DEPTH);

    // Architectural state
    logic            n_q, z_q, p_q, n_d, z_d, p_d;
    logic            ben_q, ben_d;
    logic            priv_q, priv_d;
    logic [2:0]      pri_q, pri_d;
    logic [PW-1:0]   occ_q, occ_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;

    // Stack plumbing. Each entry holds only the meaningful PSR fields:
    // {priv, pri[2:0], n, z, p}.
    logic                 push_en;
    logic                 ovf_set, unf_set;
    logic [6:0]           cur_fields;
    logic [6:0]           rd_fields;
    logic [IW-1:0]        wr_idx, rd_idx;
    logic [SLOTS*7-1:0]   slots_flat;
    logic                 cc_zero;
    logic                 unused_ir;

    assign unused_ir  = ^{ir[15:12], ir[8:0]};
    assign cur_fields = {priv_q, pri_q, n_q, z_q, p_q};
    assign wr_idx     = IW'(occ_q);
    assign rd_idx     = IW'(occ_q - PW'(1));
    assign cc_zero    = (data_bus == '0);

    assign stk_full  = (occ_q == OCC_MAX);
    assign stk_empty = (occ_q == '0);

    // One register per stack slot. The slot is written only on a successful push at its index.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        logic [6:0] slot_q;
        always_ff @(posedge clk) begin
            if (push_en && (wr_idx == IW'(gi))) begin
                slot_q <= cur_fields;
            end
        end
        assign slots_flat[gi*7 +: 7] = slot_q;
    end

    // Read the top-of-stack entry (index occ-1) for RTI.
    always_comb begin
        rd_fields = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_fields = slots_flat[i*7 +: 7];
            end
        end
    end

    // Next-state selection. PSR sources are prioritised as illegal push+pop,
    // then push, then pop, then ld_psr, then ld_cc.
    always_comb begin
        n_d     = n_q;
        z_d     = z_q;
        p_d     = p_q;
        priv_d  = priv_q;
        pri_d   = pri_q;
        occ_d   = occ_q;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (int_push && rti_pop) begin
            ovf_set = 1'b1;
        end else if (int_push) begin
            if (stk_full) begin
                ovf_set = 1'b1;
            end else begin
                push_en = 1'b1;
                occ_d   = occ_q + PW'(1);
            end
            // The mode switch happens even if the stack had no room.
            priv_d = 1'b0;
            pri_d  = int_pri;
            n_d    = 1'b0;
            z_d    = 1'b0;
            p_d    = 1'b0;
        end else if (rti_pop) begin
            if (stk_empty) begin
                unf_set = 1'b1;
            end else begin
                occ_d = occ_q - PW'(1);
                {priv_d, pri_d, n_d, z_d, p_d} = rd_fields;
            end
        end else if (ld_psr) begin
            priv_d = data_bus[15];
            pri_d  = data_bus[10:8];
            {n_d, z_d, p_d} = data_bus[2:0];
        end else if (ld_cc) begin
            n_d = data_bus[WIDTH-1];
            z_d = cc_zero;
            p_d = ~data_bus[WIDTH-1] & ~cc_zero;
        end

        // BEN always uses the condition codes from before this edge.
        ben_d = ld_ben ? |(ir[11:9] & {n_q, z_q, p_q}) : ben_q;

        // A new error in the same cycle takes precedence over the clear.
        ovf_d = ovf_set | (ovf_q & ~err_clr);
        unf_d = unf_set | (unf_q & ~err_clr);
    end

    // State registers with synchronous reset. Stack contents are not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            p_q    <= 1'b0;
            ben_q  <= 1'b0;
            priv_q <= 1'b0;
            pri_q  <= 3'd0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            n_q    <= n_d;
            z_q    <= z_d;
            p_q    <= p_d;
            ben_q  <= ben_d;
            priv_q <= priv_d;
            pri_q  <= pri_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign ben     = ben_q;
    assign n       = n_q;
    assign z       = z_q;
    assign p       = p_q;
    assign priv    = priv_q;
    assign pri     = pri_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
    assign psr     = {priv_q, 4'b0000, pri_q, 5'b00000, n_q, z_q, p_q};

endmodule

// File: tb/tb_lc3_psr_cc.sv
// Self-checking bench for lc3_psr_cc.
// - Directed steps cover each documented scenario.
// - A randomized phase follows, checked against a queue-based PSR model.
// - A second WIDTH=24 instance checks sign detection on a wider bus.
module tb_lc3_psr_cc;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_bus;
    logic [23:0] data_bus24;
    logic [15:0] ir;
    logic        ld_cc, ld_ben, ld_psr, int_push, rti_pop, err_clr;
    logic [2:0]  int_pri;

    logic        ben, n, z, p, priv, stk_full, stk_empty, stk_ovf, stk_unf;
    logic [2:0]  pri;
    logic [15:0] psr;

    logic        ben24, n24, z24, p24, priv24, full24, empty24, ovf24, unf24;
    logic [2:0]  pri24;
    logic [15:0] psr24;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lc3_psr_cc #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_bus(data_bus), .ir(ir),
        .ld_cc(ld_cc), .ld_ben(ld_ben), .ld_psr(ld_psr),
        .int_push(int_push), .int_pri(int_pri), .rti_pop(rti_pop), .err_clr(err_clr),
        .ben(ben), .n(n), .z(z), .p(p), .priv(priv), .pri(pri), .psr(psr),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    lc3_psr_cc #(.WIDTH(24), .DEPTH(DEPTH)) dut24 (
        .clk(clk), .rst(rst), .data_bus(data_bus24), .ir(ir),
        .ld_cc(ld_cc), .ld_ben(ld_ben), .ld_psr(ld_psr),
        .int_push(int_push), .int_pri(int_pri), .rti_pop(rti_pop), .err_clr(err_clr),
        .ben(ben24), .n(n24), .z(z24), .p(p24), .priv(priv24), .pri(pri24), .psr(psr24),
        .stk_full(full24), .stk_empty(empty24), .stk_ovf(ovf24), .stk_unf(unf24)
    );

    // Reference model: whole PSR words on a queue
    logic [15:0] m_psr;
    logic        m_ben, m_ovf, m_unf;
    logic [15:0] m_stack[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge, using the inputs as they are now.
    task automatic model_step();
        logic        new_ovf, new_unf, nben;
        logic [15:0] w;
        nben    = ld_ben ? |(ir[11:9] & m_psr[2:0]) : m_ben;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (rst) begin
            m_psr = 16'h0000;
            m_ben = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_stack.delete();
        end else begin
            if (int_push && rti_pop) begin
                new_ovf = 1'b1;
            end else if (int_push) begin
                if (m_stack.size() == DEPTH) new_ovf = 1'b1;
                else m_stack.push_back(m_psr);
                m_psr = {8'h00, 5'b0, int_pri, 8'h00} << 0;
                m_psr = 16'h0000 | (16'(int_pri) << 8);
            end else if (rti_pop) begin
                if (m_stack.size() == 0) new_unf = 1'b1;
                else m_psr = m_stack.pop_back();
            end else if (ld_psr) begin
                m_psr = data_bus & 16'h8707;
            end else if (ld_cc) begin
                w = m_psr & 16'hFFF8;
                if ($signed(data_bus) < 0)  m_psr = w | 16'd4;
                else if (data_bus == 16'd0) m_psr = w | 16'd2;
                else                        m_psr = w | 16'd1;
            end
            m_ben = nben;
            m_ovf = new_ovf | (m_ovf & ~err_clr);
            m_unf = new_unf | (m_unf & ~err_clr);
        end
    endtask

    task automatic cmp_model();
        chk("psr",   psr, m_psr);
        chk("n",     16'(n), 16'(m_psr[2]));
        chk("z",     16'(z), 16'(m_psr[1]));
        chk("p",     16'(p), 16'(m_psr[0]));
        chk("priv",  16'(priv), 16'(m_psr[15]));
        chk("pri",   16'(pri), 16'(m_psr[10:8]));
        chk("ben",   16'(ben), 16'(m_ben));
        chk("full",  16'(stk_full), 16'(m_stack.size() == DEPTH));
        chk("empty", 16'(stk_empty), 16'(m_stack.size() == 0));
        chk("ovf",   16'(stk_ovf), 16'(m_ovf));
        chk("unf",   16'(stk_unf), 16'(m_unf));
    endtask

    task automatic clear_in();
        rst = 0; ld_cc = 0; ld_ben = 0; ld_psr = 0;
        int_push = 0; rti_pop = 0; err_clr = 0;
    endtask

    // One clock: step model, take the edge, compare, print, drop strobes.
    task automatic tick(input string what);
        model_step();
        @(posedge clk);
        #1;
        cmp_model();
        $display("%-10s psr=%h ben=%b full=%b empty=%b ovf=%b unf=%b",
                 what, psr, ben, stk_full, stk_empty, stk_ovf, stk_unf);
        clear_in();
    endtask

    initial begin
        clear_in();
        data_bus = 0; data_bus24 = 0; ir = 0; int_pri = 0;
        m_psr = 16'hxxxx; m_ben = 1'bx; m_ovf = 1'bx; m_unf = 1'bx;

        // Reset
        rst = 1; tick("reset");
        chk("rst_psr", psr, 16'h0000);
        chk("rst_empty", 16'(stk_empty), 16'd1);

        // 1: condition codes
        ld_cc = 1; data_bus = 16'h8000; data_bus24 = 24'h800000; tick("cc_neg");
        chk("cc_neg_nzp", 16'({n, z, p}), 16'b100);
        chk("cc24_neg_n", 16'(n24), 16'd1);
        ld_cc = 1; data_bus = 16'h0000; data_bus24 = 24'h008000; tick("cc_zero");
        chk("cc_zero_nzp", 16'({n, z, p}), 16'b010);
        chk("cc24_mid_p", 16'({n24, z24, p24}), 16'b001);
        ld_cc = 1; data_bus = 16'h0001; tick("cc_pos");
        chk("cc_pos_nzp", 16'({n, z, p}), 16'b001);

        // 2: BEN uses the pre-edge codes
        ld_cc = 1; data_bus = 16'h0000; tick("cc_z");
        ir = 16'h0400; ld_ben = 1; tick("ben");
        chk("ben_z", 16'(ben), 16'd1);
        ld_ben = 1; ld_cc = 1; data_bus = 16'hFFFF; tick("ben+cc");
        chk("ben_same_cyc", 16'(ben), 16'd1);
        chk("n_after", 16'(n), 16'd1);
        ld_ben = 1; tick("ben_miss");
        chk("ben_miss", 16'(ben), 16'd0);

        // 3: ld_psr, push, pop
        ld_psr = 1; data_bus = 16'h8302; tick("ld_psr");
        chk("psr_load", psr, 16'h8302);
        chk("priv_load", 16'(priv), 16'd1);
        chk("pri_load", 16'(pri), 16'd3);
        int_push = 1; int_pri = 3'd5; tick("push");
        chk("psr_push", psr, 16'h0500);
        rti_pop = 1; tick("pop");
        chk("psr_pop", psr, 16'h8302);
        chk("empty_pop", 16'(stk_empty), 16'd1);

        // 4: fill to DEPTH, then overflow, then drain in LIFO order
        for (int i = 1; i <= 5; i++) begin
            int_push = 1; int_pri = 3'(i); tick("push_n");
            chk("full_flag", 16'(stk_full), 16'(i >= 4));
            chk("ovf_flag", 16'(stk_ovf), 16'(i == 5));
        end
        chk("psr_after_ovf", psr, 16'h0500);
        rti_pop = 1; tick("pop_n"); chk("lifo1", psr, 16'h0300);
        rti_pop = 1; tick("pop_n"); chk("lifo2", psr, 16'h0200);
        rti_pop = 1; tick("pop_n"); chk("lifo3", psr, 16'h0100);
        rti_pop = 1; tick("pop_n"); chk("lifo4", psr, 16'h8302);
        chk("empty_drain", 16'(stk_empty), 16'd1);

        // 5: underflow, clear, illegal push+pop, set-wins-over-clear
        err_clr = 1; tick("clr");
        rti_pop = 1; tick("unf");
        chk("unf_set", 16'(stk_unf), 16'd1);
        chk("unf_psr", psr, 16'h8302);
        err_clr = 1; tick("clr");
        chk("clr_flags", 16'({stk_ovf, stk_unf}), 16'd0);
        int_push = 1; rti_pop = 1; int_pri = 3'd6; tick("push+pop");
        chk("illegal_ovf", 16'(stk_ovf), 16'd1);
        chk("illegal_psr", psr, 16'h8302);
        chk("illegal_empty", 16'(stk_empty), 16'd1);
        err_clr = 1; rti_pop = 1; tick("clr+unf");
        chk("set_wins", 16'({stk_ovf, stk_unf}), 16'b01);

        // 6: reset mid-sequence discards the stack
        int_push = 1; int_pri = 3'd1; tick("push");
        int_push = 1; int_pri = 3'd2; tick("push");
        ld_psr = 1; data_bus = 16'h0201; tick("ld_psr");
        ir = 16'h0200; ld_ben = 1; tick("ben");
        chk("ben_pre_rst", 16'(ben), 16'd1);
        rst = 1; tick("reset");
        chk("rst2_psr", psr, 16'h0000);
        chk("rst2_ben", 16'(ben), 16'd0);
        chk("rst2_empty", 16'(stk_empty), 16'd1);
        rti_pop = 1; tick("pop_rst");
        chk("unf_after_rst", 16'(stk_unf), 16'd1);

        // Randomized phase checked against the model
        for (int c = 0; c < 400; c++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            data_bus   = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 : 16'($urandom);
            data_bus24 = 24'($urandom);
            ir         = 16'($urandom);
            int_pri    = 3'($urandom);
            rst        = ($urandom_range(0, 59) == 0);
            ld_cc      = ($urandom_range(0, 2) == 0);
            ld_ben     = ($urandom_range(0, 2) == 0);
            ld_psr     = ($urandom_range(0, 5) == 0);
            int_push   = ($urandom_range(0, 4) == 0);
            rti_pop    = ($urandom_range(0, 4) == 0);
            err_clr    = ($urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
